mem_port_arbiter: RTL

- Shares one single-port, fixed-latency data/instruction SRAM between the IF stage (instruction fetch, read-only) and the MEM stage (load/store).
- Sequences each access through a small FSM and wait counter.
- Returns the read data with a one-cycle ready pulse.
- Generates the freeze signals that stall the pipeline while an access is outstanding.
- Sits between the IF/MEM stages and the SRAM; instantiated in the arm top level.

---
 rtl/mem_port_arbiter_pkg.sv | 25 ++
 rtl/mem_port_arbiter_if.sv | 38 +++
 rtl/mem_port_arbiter_wait_counter.sv | 38 +++
 rtl/mem_port_arbiter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and widths for the IF/MEM SRAM port arbiter.
// The optional ARB_PERF_CNT_EN build uses sat_inc32 for its stall counters.
package arm_mem_pkg;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IF   = 2'd1,
    GNT_MEM  = 2'd2
  } arb_grant_e;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester, SRAM and freeze signal bundle of mem_port_arbiter.
// The arbiter uses the slave modport; its environment uses master.
interface mem_port_arbiter_if
  import arm_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              sram_en;
  logic              sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;
  logic              if_freeze;
  logic              mem_freeze;

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, sram_rdata,
    output if_rdata, if_ready, mem_rdata, mem_ready,
    output sram_en, sram_we, sram_addr, sram_wdata, if_freeze, mem_freeze
  );

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, sram_rdata,
    input  if_rdata, if_ready, mem_rdata, mem_ready,
    input  sram_en, sram_we, sram_addr, sram_wdata, if_freeze, mem_freeze
  );
endinterface

// File: rtl/mem_port_arbiter_wait_counter.sv
// Loadable down-counter that times the SRAM access window; zero marks
// the last access cycle.
module arb_wait_counter
  import arm_mem_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // load has priority; otherwise count down and hold at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != {CNT_W{1'b0}})) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == {CNT_W{1'b0}});
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency SRAM between IF fetches and MEM loads/stores.
// Optional ARB_PERF_CNT_EN adds saturating per-stage stall counters.
module mem_port_arbiter
  import arm_mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned MEM_LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]       if_stall_cnt,
  output logic [31:0]       mem_stall_cnt
`endif
);
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(MEM_LATENCY - 1);

  arb_state_e        state_q, state_d;
  arb_grant_e        grant_q, grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              cnt_load_s, cnt_en_s, cnt_zero_s;
  logic              sram_en_q, sram_en_d, sram_we_q, sram_we_d;
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [DATA_W-1:0] sram_wdata_q, sram_wdata_d;
  logic              if_ready_q, if_ready_d, mem_ready_q, mem_ready_d;
  logic              mem_freeze_s;

  assign cnt_load_s = (state_q == IDLE) && (state_d == ACCESS);
  assign cnt_en_s   = (state_q == ACCESS);

  arb_wait_counter u_wait (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load_s),
    .load_val (WAIT_LOAD),
    .en       (cnt_en_s),
    .zero     (cnt_zero_s)
  );

  // state, grant, latched request and captured response
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= GNT_NONE;
      addr_q  <= {ADDR_W{1'b0}};
      we_q    <= 1'b0;
      wdata_q <= {DATA_W{1'b0}};
      rdata_q <= {DATA_W{1'b0}};
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // next state; MEM wins a tie because it holds the older instruction
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (bus.mem_req) begin
          state_d = ACCESS;
          grant_d = GNT_MEM;
          addr_d  = bus.mem_addr;
          we_d    = bus.mem_we;
          wdata_d = bus.mem_wdata;
        end else if (bus.if_req) begin
          state_d = ACCESS;
          grant_d = GNT_IF;
          addr_d  = bus.if_addr;
          we_d    = 1'b0;
        end else begin
          state_d = IDLE;
          grant_d = GNT_NONE;
        end
      end
      ACCESS: begin
        if (cnt_zero_s) begin
          state_d = RESP;
          rdata_d = bus.sram_rdata;
        end else begin
          state_d = ACCESS;
        end
      end
      RESP:    state_d = IDLE;
      default: begin
        state_d = IDLE;
        grant_d = GNT_NONE;
      end
    endcase
  end

  // outputs decoded from the next state so they leave the flops cleanly
  always_comb begin
    sram_en_d    = 1'b0;
    sram_we_d    = 1'b0;
    sram_addr_d  = {ADDR_W{1'b0}};
    sram_wdata_d = {DATA_W{1'b0}};
    if_ready_d   = 1'b0;
    mem_ready_d  = 1'b0;
    case (state_d)
      ACCESS: begin
        sram_en_d    = 1'b1;
        sram_we_d    = we_d;
        sram_addr_d  = addr_d;
        sram_wdata_d = wdata_d;
      end
      RESP: begin
        if_ready_d  = (grant_d == GNT_IF);
        mem_ready_d = (grant_d == GNT_MEM);
      end
      IDLE:    begin end
      default: begin end
    endcase
  end

  // output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sram_en_q    <= 1'b0;
      sram_we_q    <= 1'b0;
      sram_addr_q  <= {ADDR_W{1'b0}};
      sram_wdata_q <= {DATA_W{1'b0}};
      if_ready_q   <= 1'b0;
      mem_ready_q  <= 1'b0;
    end else begin
      sram_en_q    <= sram_en_d;
      sram_we_q    <= sram_we_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
      if_ready_q   <= if_ready_d;
      mem_ready_q  <= mem_ready_d;
    end
  end

  assign bus.sram_en    = sram_en_q;
  assign bus.sram_we    = sram_we_q;
  assign bus.sram_addr  = sram_addr_q;
  assign bus.sram_wdata = sram_wdata_q;
  assign bus.if_ready   = if_ready_q;
  assign bus.mem_ready  = mem_ready_q;
  assign bus.if_rdata   = rdata_q;
  assign bus.mem_rdata  = rdata_q;

  assign mem_freeze_s   = bus.mem_req & ~mem_ready_q;
  assign bus.mem_freeze = mem_freeze_s;
  assign bus.if_freeze  = (bus.if_req & ~if_ready_q) | mem_freeze_s;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] if_stall_q, if_stall_d, mem_stall_q, mem_stall_d;

  // stall counters advance on every frozen cycle and saturate
  always_comb begin
    if_stall_d  = bus.if_freeze ? sat_inc32(if_stall_q) : if_stall_q;
    mem_stall_d = mem_freeze_s ? sat_inc32(mem_stall_q) : mem_stall_q;
  end

  // stall counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      if_stall_q  <= 32'd0;
      mem_stall_q <= 32'd0;
    end else begin
      if_stall_q  <= if_stall_d;
      mem_stall_q <= mem_stall_d;
    end
  end

  assign if_stall_cnt  = if_stall_q;
  assign mem_stall_cnt = mem_stall_q;
`endif
endmodule
